// File: rtl/fetch_decode_queue_pkg.sv
// Shared definitions for the fetch/decode instruction queue.
// Entry layout and default queue depth.
package fetch_decode_queue_pkg;

  localparam int FQ_DEPTH = 4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus_4;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_decode_queue_fq_pointer.sv
// Circular-buffer pointer with increment enable and load.
// Load wins over increment; wraps modulo 2**PW.
module fq_pointer
  import fetch_decode_queue_pkg::*;
#(
  parameter int PW = 3
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          inc,
  input  logic          load,
  input  logic [PW-1:0] load_val,
  output logic [PW-1:0] ptr
);

  // pointer register: load has priority over increment
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ptr <= '0;
    end else if (load) begin
      ptr <= load_val;
    end else if (inc) begin
      ptr <= ptr + PW'(1);
    end
  end

endmodule

// File: rtl/fetch_decode_queue.sv
// Fetch-to-decode instruction queue with valid/ready to decode.
// Optional zero-latency path when empty: FETCH_QUEUE_BYPASS_EN.
module fetch_decode_queue
  import fetch_decode_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] Instr_F,
  input  logic [31:0] PC_F,
  input  logic [31:0] PC_Plus_4_F,
  input  logic        Flush,
  input  logic        Ready_D,
  output logic        PC_En,
  output logic        Valid_D,
  output logic [31:0] Instr_D,
  output logic [31:0] PC_D,
  output logic [31:0] PC_Plus_4_D
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  fetch_entry_t  mem [DEPTH];
  fetch_entry_t  f_ent;
  fetch_entry_t  h_ent;
  logic          empty;
  logic          full;
  logic          enq;
  logic          deq;
  logic          byp;

  assign f_ent.instr     = Instr_F;
  assign f_ent.pc        = PC_F;
  assign f_ent.pc_plus_4 = PC_Plus_4_F;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0])
              && (wr_ptr[AW] != rd_ptr[AW]);

  assign PC_En = !full;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign byp = empty && Ready_D && !Flush;
`else
  assign byp = 1'b0;
`endif

  assign enq = PC_En && !Flush && !byp;
  assign deq = !empty && Ready_D && !Flush;

  fq_pointer #(.PW(PW)) u_wr (
    .CLK      (CLK),
    .RST      (RST),
    .inc      (enq),
    .load     (1'b0),
    .load_val ('0),
    .ptr      (wr_ptr)
  );

  fq_pointer #(.PW(PW)) u_rd (
    .CLK      (CLK),
    .RST      (RST),
    .inc      (deq),
    .load     (Flush),
    .load_val (wr_ptr),
    .ptr      (rd_ptr)
  );

  // entry storage; contents are don't-care until written
  always_ff @(posedge CLK) begin
    if (enq) begin
      mem[wr_ptr[AW-1:0]] <= f_ent;
    end
  end

  // head selection: bypassed fetch data, stored head, or zeros
  always_comb begin
    h_ent   = '0;
    Valid_D = 1'b0;
    if (byp) begin
      h_ent   = f_ent;
      Valid_D = 1'b1;
    end else if (!empty) begin
      h_ent   = mem[rd_ptr[AW-1:0]];
      Valid_D = 1'b1;
    end
  end

  assign Instr_D     = h_ent.instr;
  assign PC_D        = h_ent.pc;
  assign PC_Plus_4_D = h_ent.pc_plus_4;

endmodule
